// File: rtl/phy_tx_ctrl_pkg.sv
// Package wrapper around the shared defines so RTL and bench can import
// the state type and the fixed words.
package phy_tx_ctrl_pkg;
  `include "phy_tx_defs.vh"
endpackage

// File: rtl/phy_tx_defs.vh
// Shared constants for the PHY TX controller: FSM state encodings and the
// fixed training / idle words placed on data_out.
`ifndef PHY_TX_DEFS_VH
`define PHY_TX_DEFS_VH

typedef enum logic [1:0] {
  ST_OFF    = 2'd0,
  ST_TRAIN  = 2'd1,
  ST_ACTIVE = 2'd2
} phy_state_e;

localparam logic [31:0] TS_WORD   = 32'hBCBC_BCBC;
localparam logic [31:0] IDLE_WORD = 32'h0000_0000;

`endif

// File: rtl/phy_tx_rr_arb.sv
// Two-way round-robin arbiter with a per-owner burst limit. The owner
// (last granted) keeps the link until its burst reaches MAX_BURST or it
// stops requesting.
module phy_tx_rr_arb #(
  parameter int MAX_BURST = 8
) (
  input  logic clk_f,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  input  logic req_0,
  input  logic req_1,
  output logic gnt_0,
  output logic gnt_1
);

  logic       last_q, last_d;
  logic [7:0] burst_q, burst_d;
  logic       req_last, req_other, owner_keep;
  logic       g_last, g_other;

  assign req_last  = last_q ? req_1 : req_0;
  assign req_other = last_q ? req_0 : req_1;
  // A zero burst count means no owner yet, so requester 0 wins first.
  assign owner_keep = (burst_q != 8'd0) && req_last && (burst_q < 8'(MAX_BURST));

  always_comb begin
    g_last  = 1'b0;
    g_other = 1'b0;
    last_d  = last_q;
    burst_d = burst_q;
    if (clr_i) begin
      last_d  = 1'b1;
      burst_d = 8'd0;
    end else if (en_i) begin
      if (owner_keep) begin
        g_last  = 1'b1;
        burst_d = burst_q + 8'd1;
      end else if (req_other) begin
        g_other = 1'b1;
        last_d  = ~last_q;
        burst_d = 8'd1;
      end else if (req_last) begin
        g_last  = 1'b1;
        burst_d = 8'd1;
      end
    end
  end

  assign gnt_0 = (g_last & ~last_q) | (g_other & last_q);
  assign gnt_1 = (g_last & last_q) | (g_other & ~last_q);

  always_ff @(posedge clk_f) begin
    if (reset) begin
      last_q  <= 1'b1;
      burst_q <= 8'd0;
    end else begin
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: rtl/phy_tx_ctrl.sv
// PHY TX link controller: OFF/TRAIN/ACTIVE FSM, training word sequencer and
// registered output stage fed by a two-way round-robin arbiter.
module phy_tx_ctrl
  import phy_tx_ctrl_pkg::*;
#(
  parameter int TS_LEN    = 16,
  parameter int MAX_BURST = 8
) (
  input  logic        clk_f,
  input  logic        reset,
  input  logic        link_en,
  input  logic        req_0,
  input  logic        req_1,
  input  logic [31:0] data_0,
  input  logic [31:0] data_1,
  output logic        gnt_0,
  output logic        gnt_1,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic [1:0]  state_out
);

  phy_state_e  state_q, state_d;
  logic [7:0]  ts_cnt_q, ts_cnt_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        arb_en, arb_clr;

  assign arb_en  = (state_q == ST_ACTIVE) && link_en && !reset;
  assign arb_clr = (state_q != ST_ACTIVE);

  phy_tx_rr_arb #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk_f (clk_f),
    .reset (reset),
    .clr_i (arb_clr),
    .en_i  (arb_en),
    .req_0 (req_0),
    .req_1 (req_1),
    .gnt_0 (gnt_0),
    .gnt_1 (gnt_1)
  );

  always_comb begin
    state_d  = state_q;
    ts_cnt_d = ts_cnt_q;
    data_d   = IDLE_WORD;
    valid_d  = 1'b0;
    case (state_q)
      ST_OFF: begin
        ts_cnt_d = 8'd0;
        if (link_en) state_d = ST_TRAIN;
      end
      ST_TRAIN: begin
        if (!link_en) begin
          state_d  = ST_OFF;
          ts_cnt_d = 8'd0;
        end else begin
          data_d   = TS_WORD;
          valid_d  = 1'b1;
          ts_cnt_d = ts_cnt_q + 8'd1;
          if (ts_cnt_q == 8'(TS_LEN - 1)) begin
            state_d  = ST_ACTIVE;
            ts_cnt_d = 8'd0;
          end
        end
      end
      ST_ACTIVE: begin
        if (!link_en) begin
          state_d = ST_OFF;
        end else if (gnt_0) begin
          data_d  = data_0;
          valid_d = 1'b1;
        end else if (gnt_1) begin
          data_d  = data_1;
          valid_d = 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge clk_f) begin
    if (reset) begin
      state_q  <= ST_OFF;
      ts_cnt_q <= 8'd0;
      data_q   <= IDLE_WORD;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ts_cnt_q <= ts_cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_phy_tx_ctrl.sv
// Directed bench for phy_tx_ctrl: training sequence, arbitration patterns,
// link drop during training and reset mid-burst.
module tb_phy_tx_ctrl;
  import phy_tx_ctrl_pkg::*;

  localparam int TS_LEN = 16;

  logic        clk_f = 1'b0;
  logic        reset;
  logic        link_en;
  logic        req_0, req_1;
  logic [31:0] data_0, data_1;
  logic        gnt_0, gnt_1;
  logic [31:0] data_out;
  logic        valid_out;
  logic [1:0]  state_out;

  int checks = 0;
  int errors = 0;

  phy_tx_ctrl #(.TS_LEN(TS_LEN), .MAX_BURST(8)) dut (
    .clk_f     (clk_f),
    .reset     (reset),
    .link_en   (link_en),
    .req_0     (req_0),
    .req_1     (req_1),
    .data_0    (data_0),
    .data_1    (data_1),
    .gnt_0     (gnt_0),
    .gnt_1     (gnt_1),
    .data_out  (data_out),
    .valid_out (valid_out),
    .state_out (state_out)
  );

  always #5 clk_f = ~clk_f;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_f);
    #1;
  endtask

  // Check grants for the current inputs, clock once, check the registered word.
  task automatic step_exp(input string tag, input logic eg0, input logic eg1);
    logic [31:0] ed;
    #1;
    check_eq({tag, "_gnt0"}, {31'b0, gnt_0}, {31'b0, eg0});
    check_eq({tag, "_gnt1"}, {31'b0, gnt_1}, {31'b0, eg1});
    ed = eg0 ? data_0 : (eg1 ? data_1 : 32'h0);
    tick();
    check_eq({tag, "_data"}, data_out, ed);
    check_eq({tag, "_valid"}, {31'b0, valid_out}, {31'b0, (eg0 | eg1)});
    $display("%s: gnt0=%0b gnt1=%0b data_out=%h valid=%0b", tag, eg0, eg1, data_out, valid_out);
  endtask

  // From OFF: one edge into TRAIN, then TS_LEN training words, ACTIVE after the last.
  task automatic do_training(input string tag);
    link_en = 1'b1;
    #1;
    check_eq({tag, "_off_gnt"}, {31'b0, gnt_0 | gnt_1}, 32'h0);
    tick();
    check_eq({tag, "_st_train"}, {30'b0, state_out}, 32'd1);
    check_eq({tag, "_v0"}, {31'b0, valid_out}, 32'h0);
    for (int w = 1; w <= TS_LEN; w++) begin
      #1;
      check_eq({tag, "_tr_gnt"}, {31'b0, gnt_0 | gnt_1}, 32'h0);
      tick();
      check_eq({tag, "_ts_data"}, data_out, 32'hBCBC_BCBC);
      check_eq({tag, "_ts_valid"}, {31'b0, valid_out}, 32'h1);
      check_eq({tag, "_ts_state"}, {30'b0, state_out}, (w == TS_LEN) ? 32'd2 : 32'd1);
    end
    $display("%s: training done state_out=%0d", tag, state_out);
  endtask

  initial begin
    reset = 1'b1; link_en = 1'b1; req_0 = 1'b1; req_1 = 1'b1;
    data_0 = 32'h0; data_1 = 32'h0;
    #1;
    check_eq("rst_gnt0", {31'b0, gnt_0}, 32'h0);
    check_eq("rst_gnt1", {31'b0, gnt_1}, 32'h0);
    tick();
    tick();
    check_eq("rst_state", {30'b0, state_out}, 32'd0);
    check_eq("rst_data", data_out, 32'h0);
    check_eq("rst_valid", {31'b0, valid_out}, 32'h0);
    $display("reset: state_out=%0d data_out=%h valid=%0b", state_out, data_out, valid_out);

    // Bring-up with both requests pending from before ACTIVE.
    reset = 1'b0;
    do_training("train1");

    // Both held: 8 words to requester 0, then 8 to requester 1, repeating.
    for (int i = 0; i < 32; i++) begin
      data_0 = 32'hA000_0000 | i;
      data_1 = 32'hB000_0000 | i;
      step_exp($sformatf("both%0d", i), ((i / 8) % 2) == 0, ((i / 8) % 2) == 1);
    end

    // Requester 1 owns with a full burst: 3 grants to 0, then 0 drops.
    for (int i = 0; i < 3; i++) begin
      data_0 = 32'hC000_0000 | i;
      step_exp($sformatf("drop_pre%0d", i), 1'b1, 1'b0);
    end
    req_0 = 1'b0;
    data_1 = 32'hD000_0000;
    step_exp("drop_g1", 1'b0, 1'b1);
    // Burst of 1 restarted at 1: seven more grants, then back to 0.
    req_0 = 1'b1;
    for (int i = 1; i < 8; i++) begin
      data_1 = 32'hD000_0000 | i;
      step_exp($sformatf("drop_burst%0d", i), 1'b0, 1'b1);
    end
    data_0 = 32'hC000_00FF;
    step_exp("drop_back0", 1'b1, 1'b0);

    // Only requester 0 for 20 cycles: no bubble at the burst limit.
    req_1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      data_0 = 32'h100 + i;
      step_exp($sformatf("only0_%0d", i), 1'b1, 1'b0);
    end
    req_0 = 1'b0;
    step_exp("idle", 1'b0, 1'b0);

    // Link drop from ACTIVE, then abort training at word 5.
    req_0 = 1'b1;
    link_en = 1'b0;
    #1;
    check_eq("down_gnt", {31'b0, gnt_0 | gnt_1}, 32'h0);
    tick();
    check_eq("down_state", {30'b0, state_out}, 32'd0);
    check_eq("down_valid", {31'b0, valid_out}, 32'h0);
    link_en = 1'b1;
    tick();
    check_eq("re_train_st", {30'b0, state_out}, 32'd1);
    for (int w = 1; w <= 4; w++) begin
      tick();
      check_eq("abort_pre_valid", {31'b0, valid_out}, 32'h1);
    end
    link_en = 1'b0;
    #1;
    check_eq("abort_gnt", {31'b0, gnt_0 | gnt_1}, 32'h0);
    tick();
    check_eq("abort_state", {30'b0, state_out}, 32'd0);
    check_eq("abort_valid", {31'b0, valid_out}, 32'h0);
    check_eq("abort_data", data_out, 32'h0);
    $display("abort: state_out=%0d valid=%0b", state_out, valid_out);
    do_training("train2");

    // Reset in the middle of requester 1's burst.
    req_1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_0 = 32'hE000_0000 | i;
      data_1 = 32'hF000_0000 | i;
      step_exp($sformatf("pre_rst%0d", i), i < 8, i >= 8);
    end
    reset = 1'b1;
    #1;
    check_eq("midrst_gnt", {31'b0, gnt_0 | gnt_1}, 32'h0);
    tick();
    check_eq("midrst_state", {30'b0, state_out}, 32'd0);
    check_eq("midrst_data", data_out, 32'h0);
    check_eq("midrst_valid", {31'b0, valid_out}, 32'h0);
    $display("midrst: state_out=%0d data_out=%h valid=%0b", state_out, data_out, valid_out);
    reset = 1'b0;
    do_training("train3");
    data_0 = 32'h1234_5678;
    data_1 = 32'h8765_4321;
    step_exp("first_after_rst", 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
